// File: rtl/mips_mc_control_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, funct codes,
// ALU control codes, mux select codes, exception causes, FSM states, strobe bundle.
package mips_mc_control_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_EXC    = 2'b11;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_OVF  = 2'b01;
  localparam logic [1:0] CAUSE_ILL  = 2'b10;
  localparam logic [1:0] CAUSE_TMO  = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_RWB, S_IEXEC, S_IWB, S_BRANCH, S_JUMP, S_EXC
  } state_t;

  typedef enum logic [1:0] {AOP_ADD, AOP_SUB, AOP_FUNCT} alu_op_t;

  // One bundle of datapath strobes so reset can blank all of them at once.
  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    alu_op_t    alu_op;
    logic [1:0] pc_source;
    logic       exception;
  } ctrl_t;

endpackage

// File: rtl/mips_alu_decoder.sv
// Maps the FSM's ALU operation class plus the R-type funct field to an ALU control code.
module mips_alu_decoder
  import mips_mc_control_pkg::*;
#(
  parameter int FUNCT_W = 6
) (
  input  alu_op_t              alu_op,
  input  logic [FUNCT_W-1:0]   funct,
  output logic [3:0]           alu_ctrl
);

  // Unknown funct codes fall back to ADD so the datapath never sees an undefined op.
  always_comb begin
    alu_ctrl = ALU_ADD;
    case (alu_op)
      AOP_SUB: alu_ctrl = ALU_SUB;
      AOP_FUNCT: begin
        case (funct)
          FUNCT_W'(F_ADD): alu_ctrl = ALU_ADD;
          FUNCT_W'(F_SUB): alu_ctrl = ALU_SUB;
          FUNCT_W'(F_AND): alu_ctrl = ALU_AND;
          FUNCT_W'(F_OR):  alu_ctrl = ALU_OR;
          FUNCT_W'(F_SLT): alu_ctrl = ALU_SLT;
          default:         alu_ctrl = ALU_ADD;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control FSM with overflow / illegal-opcode / memory-timeout exceptions.
// Optional performance counters are built when MIPS_MC_PERF_CNT_EN is defined.
module mips_mc_control
  import mips_mc_control_pkg::*;
#(
  parameter int OP_W        = 6,
  parameter int FUNCT_W     = 6,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    opcode,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               overflow,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               ir_write,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [3:0]         alu_ctrl,
  output logic [1:0]         pc_source,
  output logic               exception,
  output logic [1:0]         exc_cause,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   instr_cnt
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

  state_t            state, state_nxt;
  logic [WCNT_W-1:0] wait_cnt;
  logic              wait_hit;
  logic [1:0]        cause_nxt;
  ctrl_t             ctrl, ctrl_q;
  logic [3:0]        alu_ctrl_raw;

  // This wait cycle is the last one allowed; a mem_ready in it still takes priority.
  assign wait_hit = (wait_cnt == WCNT_W'(MEM_TIMEOUT - 1));

  // Next-state selection; memory-wait states self-loop until ready or timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  state_nxt = mem_ready ? S_DECODE : (wait_hit ? S_EXC : S_FETCH);
      S_DECODE: begin
        case (opcode)
          OP_W'(OP_R):                 state_nxt = S_EXEC;
          OP_W'(OP_LW), OP_W'(OP_SW):  state_nxt = S_MEMADR;
          OP_W'(OP_BEQ):               state_nxt = S_BRANCH;
          OP_W'(OP_ADDI):              state_nxt = S_IEXEC;
          OP_W'(OP_J):                 state_nxt = S_JUMP;
          default:                     state_nxt = S_EXC;
        endcase
      end
      S_MEMADR: state_nxt = (opcode == OP_W'(OP_LW)) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_nxt = mem_ready ? S_MEMWB : (wait_hit ? S_EXC : S_MEMRD);
      S_MEMWR:  state_nxt = mem_ready ? S_FETCH : (wait_hit ? S_EXC : S_MEMWR);
      S_EXEC:   state_nxt = overflow ? S_EXC : S_RWB;
      S_IEXEC:  state_nxt = overflow ? S_EXC : S_IWB;
      default:  state_nxt = S_FETCH;
    endcase
  end

  // The only way into EXC from a given state fixes the cause.
  always_comb begin
    case (state)
      S_DECODE:         cause_nxt = CAUSE_ILL;
      S_EXEC, S_IEXEC:  cause_nxt = CAUSE_OVF;
      default:          cause_nxt = CAUSE_TMO;
    endcase
  end

  // State, wait counter (restarts whenever the state changes) and sticky exception cause.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_FETCH;
      wait_cnt  <= '0;
      exc_cause <= CAUSE_NONE;
    end else begin
      state    <= state_nxt;
      wait_cnt <= (state_nxt == state) ? wait_cnt + 1'b1 : '0;
      if (state_nxt == S_EXC && state != S_EXC) exc_cause <= cause_nxt;
    end
  end

  // Moore strobes per state; FETCH's ir_write/pc_write follow mem_ready directly.
  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = AOP_ADD;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
        ctrl.pc_source = PCSRC_ALU;
      end
      S_DECODE: ctrl.alu_src_b = SRCB_IMMSH;
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = AOP_FUNCT;
      end
      S_RWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_IEXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_IWB: ctrl.reg_write = 1'b1;
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = AOP_SUB;
        ctrl.pc_source = PCSRC_ALUOUT;
        ctrl.pc_write  = zero;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      S_EXC: begin
        ctrl.exception = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_EXC;
      end
      default: ;
    endcase
  end

  mips_alu_decoder #(.FUNCT_W(FUNCT_W)) u_alu_dec (
    .alu_op   (ctrl.alu_op),
    .funct    (funct),
    .alu_ctrl (alu_ctrl_raw)
  );

  // Reset blanks every strobe asynchronously so an in-flight access is dropped at once.
  always_comb ctrl_q = reset ? '0 : ctrl;

  assign pc_write   = ctrl_q.pc_write;
  assign ir_write   = ctrl_q.ir_write;
  assign i_or_d     = ctrl_q.i_or_d;
  assign mem_read   = ctrl_q.mem_read;
  assign mem_write  = ctrl_q.mem_write;
  assign reg_write  = ctrl_q.reg_write;
  assign reg_dst    = ctrl_q.reg_dst;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign alu_src_a  = ctrl_q.alu_src_a;
  assign alu_src_b  = ctrl_q.alu_src_b;
  assign pc_source  = ctrl_q.pc_source;
  assign exception  = ctrl_q.exception;
  assign alu_ctrl   = reset ? 4'b0000 : alu_ctrl_raw;

`ifdef MIPS_MC_PERF_CNT_EN
  logic retire;
  assign retire = (state_nxt == S_FETCH) && (state != S_FETCH) && (state != S_EXC);

  // Free-running cycle count and retired-instruction count, both wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (retire) instr_cnt <= instr_cnt + 1'b1;
    end
  end
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_mips_mc_control.sv
// Randomized bench for mips_mc_control. Each instruction is expanded into a per-cycle
// script of inputs and expected strobes derived from the instruction-level rules.
module tb_mips_mc_control;

  localparam int T     = 4;
  localparam int CNT_W = 32;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

  logic clk = 1'b0;
  logic reset;
  logic [5:0] opcode, funct;
  logic overflow, zero, mem_ready;
  logic pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, pc_source, exc_cause;
  logic [3:0] alu_ctrl;
  logic exception;
  logic [CNT_W-1:0] cycle_cnt, instr_cnt;

  mips_mc_control #(.OP_W(6), .FUNCT_W(6), .MEM_TIMEOUT(T), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .overflow(overflow),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_ctrl(alu_ctrl), .pc_source(pc_source), .exception(exception), .exc_cause(exc_cause),
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic rdy, ovf, zro;
    logic [1:0] cause;
    logic mem_read, mem_write, i_or_d, ir_write, pc_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, pc_source;
    logic [3:0] alu;
    logic exception;
  } step_t;

  int checks = 0, failures = 0;
  int cyc = 0, ins = 0;
  logic [1:0] cause_m = 2'b00;
  logic retire_m;
  step_t q[$];

  logic [18:0] obs;
  assign obs = {mem_read, mem_write, i_or_d, ir_write, pc_write, reg_write, reg_dst, mem_to_reg,
                alu_src_a, alu_src_b, pc_source, alu_ctrl, exception};

  function automatic logic [18:0] vec(step_t s);
    return {s.mem_read, s.mem_write, s.i_or_d, s.ir_write, s.pc_write, s.reg_write, s.reg_dst,
            s.mem_to_reg, s.alu_src_a, s.alu_src_b, s.pc_source, s.alu, s.exception};
  endfunction

  function automatic logic [3:0] exp_alu(logic [5:0] fn);
    case (fn)
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b101010: return 4'b0111;
      default:   return 4'b0010;
    endcase
  endfunction

  function automatic step_t blank(logic rdy);
    step_t s;
    s = '0;
    s.rdy = rdy;
    s.ovf = 1'($urandom);
    s.zro = 1'($urandom);
    s.alu = 4'b0010;
    return s;
  endfunction

  function automatic step_t exc_step(logic [1:0] c);
    step_t s;
    s = blank(1'($urandom));
    s.pc_write = 1'b1;
    s.pc_source = 2'b11;
    s.exception = 1'b1;
    s.cause = c;
    return s;
  endfunction

  // A memory phase: d cycles of not-ready, then either completion or a timeout trap.
  task automatic add_wait(int d, step_t busy, step_t done, output bit to);
    step_t s;
    to = 1'b0;
    for (int i = 0; i < d && i < T; i++) begin
      s = busy; s.rdy = 1'b0; s.ovf = 1'($urandom); s.zro = 1'($urandom);
      q.push_back(s);
    end
    if (d >= T) begin
      q.push_back(exc_step(2'b11));
      to = 1'b1;
    end else begin
      done.rdy = 1'b1;
      q.push_back(done);
    end
  endtask

  task automatic build(logic [5:0] op, logic [5:0] fn, logic ovf, logic zr, int fd, int md);
    step_t f, fdone, s, b, bdone;
    bit to;
    q.delete();
    retire_m = 1'b1;
    opcode = op;
    funct = fn;
    f = blank(1'b0); f.mem_read = 1'b1; f.alu_src_b = 2'b01;
    fdone = f; fdone.ir_write = 1'b1; fdone.pc_write = 1'b1;
    add_wait(fd, f, fdone, to);
    if (to) begin retire_m = 1'b0; return; end
    s = blank(1'($urandom)); s.alu_src_b = 2'b11;
    q.push_back(s);
    case (op)
      LW, SW: begin
        s = blank(1'($urandom)); s.alu_src_a = 1'b1; s.alu_src_b = 2'b10;
        q.push_back(s);
        b = blank(1'b0); b.i_or_d = 1'b1;
        if (op == LW) b.mem_read = 1'b1; else b.mem_write = 1'b1;
        bdone = b;
        add_wait(md, b, bdone, to);
        if (to) begin retire_m = 1'b0; return; end
        if (op == LW) begin
          s = blank(1'($urandom)); s.reg_write = 1'b1; s.mem_to_reg = 1'b1;
          q.push_back(s);
        end
      end
      RT, ADDI: begin
        s = blank(1'($urandom)); s.alu_src_a = 1'b1; s.ovf = ovf;
        if (op == RT) s.alu = exp_alu(fn); else s.alu_src_b = 2'b10;
        q.push_back(s);
        if (ovf) begin
          q.push_back(exc_step(2'b01));
          retire_m = 1'b0;
        end else begin
          s = blank(1'($urandom)); s.reg_write = 1'b1; s.reg_dst = (op == RT);
          q.push_back(s);
        end
      end
      BEQ: begin
        s = blank(1'($urandom)); s.alu_src_a = 1'b1; s.alu = 4'b0110;
        s.pc_source = 2'b01; s.zro = zr; s.pc_write = zr;
        q.push_back(s);
      end
      JMP: begin
        s = blank(1'($urandom)); s.pc_write = 1'b1; s.pc_source = 2'b10;
        q.push_back(s);
      end
      default: begin
        q.push_back(exc_step(2'b10));
        retire_m = 1'b0;
      end
    endcase
  endtask

  // Drives the first n scripted cycles; starts and ends just after a falling edge.
  task automatic run_script(int n);
    step_t s;
    logic [CNT_W-1:0] ec, ei;
    for (int i = 0; i < n && i < q.size(); i++) begin
      s = q[i];
      mem_ready = s.rdy; overflow = s.ovf; zero = s.zro;
      if (s.exception) cause_m = s.cause;
      #1;
      checks++;
      if (obs !== vec(s)) begin
        failures++;
        $display("FAIL strobes op=%b step=%0d got=%b want=%b", opcode, i, obs, vec(s));
      end
      checks++;
      if (exc_cause !== cause_m) begin
        failures++;
        $display("FAIL exc_cause op=%b step=%0d got=%b want=%b", opcode, i, exc_cause, cause_m);
      end
`ifdef MIPS_MC_PERF_CNT_EN
      ec = CNT_W'(cyc); ei = CNT_W'(ins);
`else
      ec = '0; ei = '0;
`endif
      checks++;
      if (cycle_cnt !== ec || instr_cnt !== ei) begin
        failures++;
        $display("FAIL counters op=%b step=%0d got=%0d/%0d want=%0d/%0d", opcode, i,
                 cycle_cnt, instr_cnt, ec, ei);
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    if (n >= q.size() && retire_m) ins++;
  endtask

  task automatic test_reset();
    step_t f;
    reset = 1'b1; mem_ready = 1'b1; overflow = 1'b0; zero = 1'b0; opcode = '0; funct = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (obs !== 19'd0 || exc_cause !== 2'b00) begin
      failures++;
      $display("FAIL reset_strobes got=%b cause=%b want=0", obs, exc_cause);
    end
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b0; cyc = 0; ins = 0; cause_m = 2'b00;
    #1;
    f = blank(1'b0); f.mem_read = 1'b1; f.alu_src_b = 2'b01;
    checks++;
    if (obs !== vec(f) || cycle_cnt !== '0 || instr_cnt !== '0) begin
      failures++;
      $display("FAIL reset_release got=%b cnt=%0d/%0d want=%b cnt=0/0", obs, cycle_cnt, instr_cnt, vec(f));
    end
  endtask

  task automatic test_lw();
    build(LW, 6'd0, 1'b0, 1'b0, 0, 0); run_script(99);
    build(SW, 6'd0, 1'b0, 1'b0, 0, 0); run_script(99);
  endtask

  task automatic test_overflow();
    build(RT, 6'b100000, 1'b1, 1'b0, 0, 0); run_script(99);
    build(ADDI, 6'd0, 1'b1, 1'b0, 0, 0); run_script(99);
    build(RT, 6'b101010, 1'b0, 1'b0, 0, 0); run_script(99);
  endtask

  task automatic test_illegal();
    build(6'b111111, 6'd0, 1'b0, 1'b0, 0, 0); run_script(99);
    build(JMP, 6'd0, 1'b0, 1'b0, 0, 0); run_script(99);
  endtask

  task automatic test_timeout();
    build(SW, 6'd0, 1'b0, 1'b0, 0, T); run_script(99);
    build(SW, 6'd0, 1'b0, 1'b0, 0, T - 1); run_script(99);
    build(LW, 6'd0, 1'b0, 1'b0, 1, T); run_script(99);
    build(JMP, 6'd0, 1'b0, 1'b0, T, 0); run_script(99);
    build(JMP, 6'd0, 1'b0, 1'b0, T - 1, 0); run_script(99);
  endtask

  task automatic test_beq();
    build(BEQ, 6'd0, 1'b0, 1'b1, 0, 0); run_script(99);
    build(BEQ, 6'd0, 1'b0, 1'b0, 0, 0); run_script(99);
  endtask

  task automatic test_random();
    logic [5:0] ops [7];
    logic [5:0] fns [6];
    logic [5:0] op;
    ops = '{RT, LW, SW, BEQ, ADDI, JMP, 6'd0};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
    for (int n = 0; n < 150; n++) begin
      op = ops[$urandom_range(0, 6)];
      if (n % 7 == 6) begin
        do op = 6'($urandom);
        while (op inside {RT, LW, SW, BEQ, ADDI, JMP});
      end
      build(op, fns[$urandom_range(0, 5)], ($urandom_range(0, 3) == 0), 1'($urandom),
            $urandom_range(0, T + 1), $urandom_range(0, T + 1));
      run_script(99);
    end
  endtask

  task automatic test_reset_mid_memrd();
    step_t f;
    build(LW, 6'd0, 1'b0, 1'b0, 0, 3);
    run_script(4);
    mem_ready = 1'b0;
    #1 reset = 1'b1;
    #1;
    checks++;
    if (obs !== 19'd0 || exc_cause !== 2'b00 || cycle_cnt !== '0 || instr_cnt !== '0) begin
      failures++;
      $display("FAIL reset_mid_memrd got=%b cause=%b cnt=%0d/%0d want=0", obs, exc_cause, cycle_cnt, instr_cnt);
    end
    @(negedge clk);
    reset = 1'b0; cyc = 0; ins = 0; cause_m = 2'b00;
    #1;
    f = blank(1'b0); f.mem_read = 1'b1; f.alu_src_b = 2'b01;
    checks++;
    if (obs !== vec(f) || cycle_cnt !== '0 || instr_cnt !== '0) begin
      failures++;
      $display("FAIL reset_mid_release got=%b cnt=%0d/%0d want=%b", obs, cycle_cnt, instr_cnt, vec(f));
    end
    build(ADDI, 6'd0, 1'b0, 1'b0, 0, 0); run_script(99);
  endtask

  initial begin
    test_reset();
    test_lw();
    test_overflow();
    test_illegal();
    test_timeout();
    test_beq();
    test_random();
    test_reset_mid_memrd();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
